// File: rtl/pc_irq_sequencer_pkg.sv
// ============================================================================
//  Module      : pc_irq_sequencer_pkg
//  Description : Shared state encodings, opcodes and reset/vector defaults
//                for the PC / interrupt sequencing stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_irq_sequencer_pkg;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_ISR = 1'b1
    } state_t;

    localparam logic [5:0]  c_op_res          = 6'b11_1111;
    localparam logic [31:0] c_reset_pc_dflt   = 32'h0000_0000;
    localparam logic [31:0] c_isr_vector_dflt = 32'h0000_0200;

endpackage

`default_nettype wire

// File: rtl/pc_irq_sequencer_npc_calc.sv
// ============================================================================
//  Module      : pc_irq_sequencer_npc_calc
//  Description : Combinational next-PC: pc+4, branch/jump targets, npc mux.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_irq_sequencer_npc_calc (
    input  logic [31:0] pc,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] imm_ext,
    input  logic [25:0] jaddr,
    output logic [31:0] pc_plus4,
    output logic [31:0] npc_norm
);

    logic [31:0] w_btarget;
    logic [31:0] w_jtarget;

    assign pc_plus4  = pc + 32'd4;
    assign w_btarget = pc_plus4 + (imm_ext << 2);
    assign w_jtarget = {pc_plus4[31:28], jaddr, 2'b00};

    // Jump outranks a taken branch, which outranks sequential fetch.
    always_comb begin
        npc_norm = pc_plus4;
        if (jump) begin
            npc_norm = w_jtarget;
        end else if (branch && zero) begin
            npc_norm = w_btarget;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_irq_sequencer.sv
// ============================================================================
//  Module      : pc_irq_sequencer
//  Description : PC register, EPC save/restore and RUN/ISR interrupt sequencing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_irq_sequencer
    import pc_irq_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = c_reset_pc_dflt,
    parameter logic [31:0] ISR_VECTOR = c_isr_vector_dflt
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        irq_resume,
    input  logic [31:0] imm_ext,
    input  logic [25:0] jaddr,
    input  logic        irq_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        in_isr,
    output logic        irq_ack
);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic        r_irq_ack;
    logic [31:0] w_pc_next;
    logic [31:0] w_epc_next;
    logic        w_ack_next;
    logic [31:0] w_npc_norm;

    pc_irq_sequencer_npc_calc u_npc_calc (
        .pc       (r_pc),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .imm_ext  (imm_ext),
        .jaddr    (jaddr),
        .pc_plus4 (pc_plus4),
        .npc_norm (w_npc_norm)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_pc      <= RESET_PC;
            r_epc     <= 32'd0;
            r_irq_ack <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_epc     <= w_epc_next;
            r_irq_ack <= w_ack_next;
        end
    end

    // Hold freezes everything but the ack, which must never stretch.
    // RES in RUN is spurious and simply falls through to npc_norm.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_epc_next   = r_epc;
        w_ack_next   = 1'b0;
        if (!hold) begin
            w_pc_next = w_npc_norm;
            case (r_state)
                ST_RUN: begin
                    if (irq_req) begin
                        w_epc_next   = w_npc_norm;
                        w_pc_next    = ISR_VECTOR;
                        w_ack_next   = 1'b1;
                        w_state_next = ST_ISR;
                    end
                end
                ST_ISR: begin
                    if (irq_resume) begin
                        w_pc_next    = r_epc;
                        w_state_next = ST_RUN;
                    end
                end
                default: w_state_next = ST_RUN;
            endcase
        end
    end

    assign pc      = r_pc;
    assign epc     = r_epc;
    assign in_isr  = (r_state == ST_ISR);
    assign irq_ack = r_irq_ack;

endmodule

`default_nettype wire

// File: tb/tb_pc_irq_sequencer.sv
// ============================================================================
//  Module      : tb_pc_irq_sequencer
//  Description : Scoreboard bench for pc_irq_sequencer with a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_irq_sequencer;

    localparam logic [31:0] c_reset_pc   = 32'h0000_0000;
    localparam logic [31:0] c_isr_vector = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        jump = 1'b0;
    logic        irq_resume = 1'b0;
    logic [31:0] imm_ext = 32'd0;
    logic [25:0] jaddr = 26'd0;
    logic        irq_req = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        in_isr;
    logic        irq_ack;

    pc_irq_sequencer #(
        .RESET_PC   (c_reset_pc),
        .ISR_VECTOR (c_isr_vector)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .branch     (branch),
        .zero       (zero),
        .jump       (jump),
        .irq_resume (irq_resume),
        .imm_ext    (imm_ext),
        .jaddr      (jaddr),
        .irq_req    (irq_req),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .epc        (epc),
        .in_isr     (in_isr),
        .irq_ack    (irq_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at_cyc;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        isr;
        logic        ack;
    } exp_t;

    exp_t q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Architectural reference state
    logic [31:0] m_pc  = 32'd0;
    logic [31:0] m_epc = 32'd0;
    logic        m_isr = 1'b0;
    logic        m_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    endtask

    // Apply one cycle of controls and predict what the next cycle must show.
    task automatic step(input logic rn, input logic hd, input logic br, input logic z,
                        input logic j, input logic res, input logic [31:0] imm,
                        input logic [25:0] ja, input logic irq);
        logic [31:0] p4;
        logic [31:0] npc;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rn; hold = hd; branch = br; zero = z; jump = j;
        irq_resume = res; imm_ext = imm; jaddr = ja; irq_req = irq;
        if (!rn) begin
            m_pc = c_reset_pc; m_epc = 32'd0; m_isr = 1'b0; m_ack = 1'b0;
        end else if (hd) begin
            m_ack = 1'b0;
        end else begin
            p4 = m_pc + 32'd4;
            if (j)            npc = {p4[31:28], ja, 2'b00};
            else if (br && z) npc = p4 + imm * 32'd4;
            else              npc = p4;
            m_ack = 1'b0;
            if (!m_isr && irq) begin
                m_epc = npc; m_pc = c_isr_vector; m_isr = 1'b1; m_ack = 1'b1;
            end else if (m_isr && res) begin
                m_pc = m_epc; m_isr = 1'b0;
            end else begin
                m_pc = npc;
            end
        end
        e.at_cyc = cyc + 1;
        e.pc = m_pc; e.epc = m_epc; e.isr = m_isr; e.ack = m_ack;
        q.push_back(e);
    endtask

    task automatic idle(input logic irq);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, irq);
    endtask

    // Monitor: compares every predicted cycle once the DUT is presenting it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].at_cyc <= cyc) begin
                e = q.pop_front();
                if (e.at_cyc < cyc) begin
                    chk("stale_expect", 32'(e.at_cyc), 32'(cyc));
                end else begin
                    chk("pc",       pc,               e.pc);
                    chk("pc_plus4", pc_plus4,         e.pc + 32'd4);
                    chk("epc",      epc,              e.epc);
                    chk("in_isr",   32'(in_isr),      32'(e.isr));
                    chk("irq_ack",  32'(irq_ack),     32'(e.ack));
                end
            end
        end
    end

    initial begin
        // Reset, then free run 0,4,8,12,16
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 1'b0);
        repeat (4) idle(1'b0);
        // Branch taken at 0x10 with imm -2 -> 0x0C, then not taken at 0x10 -> 0x14
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'd0, 1'b0);
        idle(1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'd0, 1'b0);
        // Long branch from 0x14 to 0x1000_0040, then jump beats branch -> 0x1000_0400
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0400_000A, 26'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd4, 26'h000_0100, 1'b0);
        // Back to 0x20, then interrupt on a taken branch: epc = 0x34
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFBFF_FF07, 26'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd4, 26'd0, 1'b1);
        // Request masked in ISR, resume wins over a live request, then re-entry
        repeat (5) idle(1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 26'd0, 1'b1);
        idle(1'b1);
        idle(1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 26'd0, 1'b0);
        // Hold with pending request, release -> entry, then reset mid-ISR
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 1'b1);
        idle(1'b1);
        idle(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 1'b1);
        idle(1'b0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(99) != 0),
                 ($urandom_range(5) == 0),
                 ($urandom_range(3) == 0),
                 1'($urandom),
                 ($urandom_range(7) == 0),
                 ($urandom_range(4) == 0),
                 $urandom,
                 26'($urandom),
                 ($urandom_range(3) == 0));
        end

        idle(1'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
